// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
package fifo_write_arbiter_pkg;

    localparam int DEF_FIFO_WIDTH = 63;
    localparam int DEF_FIFO_DEPTH = 2048;
    localparam int DEF_FIFO_BITS  = 11;
    localparam int DEF_NUM_CH     = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_write_arbiter_rr_arbiter.sv
// Round-robin selector: picks the first requester at or after ptr, wrapping at NUM_CH.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx
);

    always_comb begin
        int   idx;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(ptr) + k) % NUM_CH;
            if (!found && req[IDX_W'(idx)]) begin
                found                 = 1'b1;
                grant[IDX_W'(idx)]    = 1'b1;
                grant_idx             = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Arbitrates NUM_CH valid/ready writers onto one FIFO write port, one word per two cycles.
// Handshake: a channel transfers on the cycle where ch_valid[i] and ch_ready[i] are both 1.
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int FIFO_BITS  = DEF_FIFO_BITS,
    parameter int NUM_CH     = DEF_NUM_CH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         arb_enable,
    input  logic [NUM_CH-1:0]            ch_valid,
    input  logic [NUM_CH*FIFO_WIDTH-1:0] ch_data,
    output logic [NUM_CH-1:0]            ch_ready,
    output logic [FIFO_WIDTH-1:0]        fifo_data_in,
    output logic                         fifo_write_n,
    input  logic                         fifo_full,
    input  logic [FIFO_BITS:0]           fifo_counter,
    output logic [31:0]                  write_count,
    output logic [1:0]                   grant_id
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [FIFO_BITS:0] DEPTH_LIM = (FIFO_BITS+1)'(FIFO_DEPTH);

    state_t                  state;
    state_t                  next_state;
    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        last_grant;
    logic [IDX_W-1:0]        sel_idx;
    logic [NUM_CH-1:0]       sel_grant;
    logic [FIFO_WIDTH-1:0]   sel_data;
    logic                    grant_ok;
    logic                    do_grant;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr (
        .req       (ch_valid),
        .ptr       (rr_ptr),
        .grant     (sel_grant),
        .grant_idx (sel_idx)
    );

    assign sel_data = ch_data[int'(sel_idx)*FIFO_WIDTH +: FIFO_WIDTH];
    assign grant_ok = !reset && arb_enable && (|ch_valid) && !fifo_full
                      && (fifo_counter < DEPTH_LIM);
    assign grant_id = 2'(last_grant);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // The strobe is a pure function of WRITE, so a committed write always completes.
    always_comb begin
        next_state   = state;
        ch_ready     = '0;
        fifo_write_n = 1'b1;
        do_grant     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_ok) begin
                    next_state = WRITE;
                    ch_ready   = sel_grant;
                    do_grant   = 1'b1;
                end
            end
            WRITE: begin
                fifo_write_n = 1'b0;
                next_state   = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr       <= '0;
            last_grant   <= '0;
            fifo_data_in <= '0;
            write_count  <= '0;
        end else begin
            if (state == WRITE) write_count <= write_count + 32'd1;
            if (do_grant) begin
                fifo_data_in <= sel_data;
                last_grant   <= sel_idx;
                rr_ptr       <= (sel_idx == IDX_W'(NUM_CH-1)) ? '0 : sel_idx + 1'b1;
            end
        end
    end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameters SHALL be: FIFO_WIDTH, default 63, word width; FIFO_DEPTH, default 2048, FIFO capacity in words; FIFO_BITS, default 11, log2(FIFO_DEPTH); NUM_CH, default 4, number of requesters.
REQ-002 clk  input  1  single clock; all logic on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 arb_enable  input  1  1 = grants permitted; 0 = finish the in-flight write, then issue no new grants.
REQ-005 ch_valid  input  NUM_CH  per-channel request; holds its word until ch_ready.
REQ-006 ch_data  input  NUM_CH x FIFO_WIDTH  per-channel word.
REQ-007 ch_ready  output  NUM_CH  one-hot or zero; a transfer occurs on a cycle where ch_valid[i] and ch_ready[i] are both 1.
REQ-008 fifo_data_in  output  FIFO_WIDTH  registered word driven to the FIFO.
REQ-009 fifo_write_n  output  1  active-low FIFO write strobe.
REQ-010 fifo_full  input  1  FIFO full status.
REQ-011 fifo_counter  input  FIFO_BITS+1  FIFO occupancy.
REQ-012 write_count  output  32  total words written since reset.
REQ-013 grant_id  output  2  index of the channel of the last grant.

Function
REQ-014 The FSM SHALL have two states: IDLE and WRITE.
REQ-015 IDLE SHALL move to WRITE when all of these hold: arb_enable=1; some ch_valid bit is 1; fifo_full=0; fifo_counter < FIFO_DEPTH.
REQ-016 On that IDLE cycle, ch_ready SHALL assert for exactly one channel: the first valid channel in round-robin order, starting at (last grant + 1) mod NUM_CH.
REQ-017 On the same edge, fifo_data_in SHALL load that channel's ch_data, and grant_id SHALL update.
REQ-018 In WRITE, fifo_write_n SHALL be 0 for exactly one cycle, and the state SHALL return to IDLE.
REQ-019 Throughput: at most one word per 2 cycles. Latency: 1 cycle from handshake to fifo_write_n low.
REQ-020 ch_ready SHALL be 0 in WRITE, and in IDLE whenever the REQ-015 conditions are not met.
REQ-021 The round-robin pointer SHALL advance only on a grant, and SHALL wrap from NUM_CH-1 to 0.
REQ-022 If only one channel is valid, it SHALL be granted on every IDLE cycle, with no starvation of later requesters.
REQ-023 fifo_full rising during WRITE SHALL NOT abort the strobe already committed; the next grant is blocked.
REQ-024 arb_enable falling during WRITE SHALL let that write complete.
REQ-025 write_count SHALL increment by 1 on each WRITE cycle and wrap at 2^32-1 -> 0.
REQ-026 fifo_data_in SHALL hold its value except on a grant edge.

Reset
REQ-027 While reset=1, the FSM SHALL be in IDLE and outputs SHALL be: fifo_write_n=1, ch_ready=0, fifo_data_in=0, write_count=0, grant_id=0.
REQ-028 Reset SHALL set the round-robin pointer so that channel 0 is checked first.
REQ-029 Reset asserted during WRITE SHALL force fifo_write_n=1 on the next edge, and the word SHALL be dropped.

Structure
REQ-030 A shared package SHALL hold the FSM state enum and the default FIFO_WIDTH, FIFO_DEPTH, FIFO_BITS and NUM_CH constants.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, pointer; outputs: one-hot grant, grant index).

Verification
REQ-032 Scenario: reset for 2 cycles, then idle -> fifo_write_n=1, ch_ready=0, write_count=0.
REQ-033 Scenario: only ch 2 valid, 5 words 0x10..0x14 -> 5 strobes, one every 2 cycles, data in order, write_count=5.
REQ-034 Scenario: all 4 channels continuously valid, data = channel id -> FIFO receives 0,1,2,3,0,1,... for 16 words.
REQ-035 Scenario: fifo_full=1 with ch 0 valid -> no ch_ready and no strobe; fifo_full=0 -> grant on the next IDLE cycle.
REQ-036 Scenario: arb_enable dropped on the grant cycle -> that strobe completes, and no further grants occur for 10 cycles.
REQ-037 Scenario: reset asserted during WRITE -> fifo_write_n=1 after the edge, and write_count=0.
